// File: rtl/jk_ctrl_pkg.sv
// Shared types for the JK bank controller: command opcodes and FSM states.
package jk_ctrl_pkg;

    typedef enum logic [2:0] {
        NOP   = 3'd0,
        SET   = 3'd1,
        CLR   = 3'd2,
        TGL   = 3'd3,
        LOAD  = 3'd4,
        CNTUP = 3'd5,
        CNTDN = 3'd6,
        RSVD  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_count(input op_e op);
        return (op == CNTUP) || (op == CNTDN);
    endfunction

endpackage

// File: rtl/jk_bank_ctrl_if.sv
// Command channel of the JK bank controller: valid/ready plus the command fields.
interface jk_bank_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
);
    import jk_ctrl_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    op_e              cmd_op;
    logic [WIDTH-1:0] cmd_mask;
    logic [WIDTH-1:0] cmd_data;
    logic [LEN_W-1:0] cmd_len;

    modport master (
        output cmd_valid, cmd_op, cmd_mask, cmd_data, cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_mask, cmd_data, cmd_len,
        output cmd_ready
    );

endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-low reset: hold / clear / set / toggle.
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= 1'b0;
        end else begin
            unique case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of JK cells: registers one command, drives J/K for
// one or more EXEC cycles, then pulses done.
module jk_bank_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    jk_bank_ctrl_if.slave    cmd,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    state_e           state;
    op_e              op_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] data_r;
    logic [LEN_W-1:0] step;
    logic             ready_r;

    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic             carry_up;
    logic             carry_dn;

    assign cmd.cmd_ready = ready_r;

    // Ripple-carry toggle enables of a synchronous binary up/down counter.
    always_comb begin
        carry_up = 1'b1;
        carry_dn = 1'b1;
        t_up     = '0;
        t_dn     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t_up[i]  = carry_up;
            t_dn[i]  = carry_dn;
            carry_up = carry_up & q[i];
            carry_dn = carry_dn & ~q[i];
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block leaves j/k unassigned (no latch).
        j = '0;
        k = '0;
        if (state == EXEC) begin
            unique case (op_r)
                SET:  j = mask_r;
                CLR:  k = mask_r;
                TGL: begin
                    j = mask_r;
                    k = mask_r;
                end
                LOAD: begin
                    j = mask_r & data_r;
                    k = mask_r & ~data_r;
                end
                // A zero-length count parks in EXEC for one cycle with step == 0.
                CNTUP: if (step != '0) begin
                    j = t_up;
                    k = t_up;
                end
                CNTDN: if (step != '0) begin
                    j = t_dn;
                    k = t_dn;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            op_r    <= NOP;
            mask_r  <= '0;
            data_r  <= '0;
            step    <= '0;
            ready_r <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    ready_r <= 1'b1;
                    if (cmd.cmd_valid && ready_r) begin
                        op_r    <= cmd.cmd_op;
                        mask_r  <= cmd.cmd_mask;
                        data_r  <= cmd.cmd_data;
                        step    <= is_count(cmd.cmd_op) ? cmd.cmd_len : LEN_W'(1);
                        ready_r <= 1'b0;
                        busy    <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (step <= LEN_W'(1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        step <= step - LEN_W'(1);
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j[i]),
            .k     (k[i]),
            .q     (q[i])
        );
    end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed bench for jk_bank_ctrl: hand-computed q/done/busy/ready expectations.
module tb_jk_bank_ctrl;
    import jk_ctrl_pkg::*;

    localparam int WIDTH = 8;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] up_seq [0:3];

    jk_bank_ctrl_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) cmd_if ();

    jk_bank_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .cmd   (cmd_if),
        .q     (q),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input op_e op, input logic [7:0] mask, input logic [7:0] data,
                         input logic [7:0] len);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_mask  = mask;
        cmd_if.cmd_data  = data;
        cmd_if.cmd_len   = len;
    endtask

    // After acceptance, scramble the fields; the DUT must use its registered copy.
    task automatic scramble();
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = TGL;
        cmd_if.cmd_mask  = ~cmd_if.cmd_mask;
        cmd_if.cmd_data  = ~cmd_if.cmd_data;
        cmd_if.cmd_len   = 8'hFF;
    endtask

    // Issues one command, returns accept cycle, cycles to done (L+1) and q in the done cycle,
    // then checks that done drops and ready returns in the following cycle.
    task automatic do_cmd(input string tag, input op_e op, input logic [7:0] mask,
                          input logic [7:0] data, input logic [7:0] len,
                          output int t_acc, output int lat, output logic [7:0] qd);
        int waited;
        waited = 0;
        while (!cmd_if.cmd_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) check({tag, "_ready_timeout"}, 32'(cmd_if.cmd_ready), 32'd1);
        drive(op, mask, data, len);
        tick();
        t_acc = cyc - 1;
        scramble();
        lat = 1;
        while (!done && lat < 300) begin
            tick();
            lat++;
        end
        qd = q;
        tick();
        check({tag, "_done_drop"}, {30'd0, done, cmd_if.cmd_ready}, 32'b01);
    endtask

    initial begin
        int         ta;
        int         tb;
        int         lat;
        int         seen;
        logic [7:0] qd;

        up_seq[0] = 8'hFE;
        up_seq[1] = 8'hFF;
        up_seq[2] = 8'h00;
        up_seq[3] = 8'h01;

        // Reset held for two edges with a command waiting.
        reset = 1'b0;
        drive(SET, 8'hFF, 8'h00, 8'h00);
        tick();
        check("rst_hold1", {q, 5'd0, cmd_if.cmd_ready, busy, done}, {8'h00, 8'h00});
        tick();
        check("rst_hold2", {q, 5'd0, cmd_if.cmd_ready, busy, done}, {8'h00, 8'h00});
        reset            = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        tick();
        check("rst_release", {q, 5'd0, cmd_if.cmd_ready, busy, done}, {8'h00, 8'h04});

        // SET then TGL, done two cycles after each accept.
        do_cmd("set", SET, 8'h0F, 8'h00, 8'h00, ta, lat, qd);
        check("set_lat", lat, 2);
        check("set_q", qd, 8'h0F);
        do_cmd("tgl", TGL, 8'hFF, 8'h00, 8'h00, ta, lat, qd);
        check("tgl_lat", lat, 2);
        check("tgl_q", qd, 8'hF0);

        // Masked LOAD and back-to-back issue interval.
        do_cmd("load0f", LOAD, 8'hFF, 8'h0F, 8'h00, ta, lat, qd);
        check("load0f_q", qd, 8'h0F);
        do_cmd("loada5", LOAD, 8'hF0, 8'hA5, 8'h00, tb, lat, qd);
        check("loada5_q", qd, 8'hAF);
        check("issue_interval", tb - ta, 3);

        // CNTUP len=3 across the wrap, then a command held valid through DONE.
        do_cmd("loadfe", LOAD, 8'hFF, 8'hFE, 8'h00, ta, lat, qd);
        check("loadfe_q", qd, 8'hFE);
        drive(CNTUP, 8'h00, 8'h00, 8'd3);
        tick();
        scramble();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cntup_q%0d", i), q, up_seq[i]);
            check($sformatf("cntup_bd%0d", i), {busy, done}, {1'b1, (i == 3)});
            if (i == 3) drive(SET, 8'hFF, 8'h00, 8'h00);
            tick();
        end
        check("done_hold_not_taken", {30'd0, busy, cmd_if.cmd_ready}, 32'b01);
        tick();
        cmd_if.cmd_valid = 1'b0;
        check("done_hold_taken", {30'd0, busy, cmd_if.cmd_ready}, 32'b10);
        seen = 0;
        while (!done && seen < 20) begin
            tick();
            seen++;
        end
        check("held_set_q", {done, q}, {1'b1, 8'hFF});
        tick();

        // Zero-length count, reserved opcode, NOP, CLR and down counts.
        do_cmd("load33", LOAD, 8'hFF, 8'h33, 8'h00, ta, lat, qd);
        do_cmd("cntdn0", CNTDN, 8'hFF, 8'h00, 8'd0, ta, lat, qd);
        check("cntdn0_lat", lat, 2);
        check("cntdn0_q", qd, 8'h33);
        do_cmd("rsvd", RSVD, 8'hFF, 8'hFF, 8'd5, ta, lat, qd);
        check("rsvd_lat", lat, 2);
        check("rsvd_q", qd, 8'h33);
        do_cmd("nop", NOP, 8'hFF, 8'hFF, 8'd5, ta, lat, qd);
        check("nop_q", qd, 8'h33);
        do_cmd("clr", CLR, 8'h0F, 8'h00, 8'd0, ta, lat, qd);
        check("clr_q", qd, 8'h30);
        do_cmd("cntdn2", CNTDN, 8'h00, 8'h00, 8'd2, ta, lat, qd);
        check("cntdn2_lat", lat, 3);
        check("cntdn2_q", qd, 8'h2E);
        do_cmd("load00", LOAD, 8'hFF, 8'h00, 8'h00, ta, lat, qd);
        do_cmd("cntdn_wrap", CNTDN, 8'h00, 8'h00, 8'd1, ta, lat, qd);
        check("cntdn_wrap_q", qd, 8'hFF);

        // Reset in the 4th EXEC cycle of a long count aborts without done.
        do_cmd("load55", LOAD, 8'hFF, 8'h55, 8'h00, ta, lat, qd);
        drive(CNTUP, 8'h00, 8'h00, 8'd10);
        tick();
        scramble();
        tick();
        tick();
        tick();
        check("abort_pre_q", {busy, done, q}, {1'b1, 1'b0, 8'h58});
        reset = 1'b0;
        tick();
        check("abort_rst", {q, 5'd0, cmd_if.cmd_ready, busy, done}, {8'h00, 8'h00});
        reset = 1'b1;
        tick();
        check("abort_release", {q, 5'd0, cmd_if.cmd_ready, busy, done}, {8'h00, 8'h04});
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            seen += int'(done) + int'(busy);
            tick();
        end
        check("abort_no_done", seen, 0);
        do_cmd("post_abort_set", SET, 8'h80, 8'h00, 8'h00, ta, lat, qd);
        check("post_abort_q", qd, 8'h80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jk_bank_ctrl.md
# jk_bank_ctrl

Command-driven controller for a WIDTH-bit bank of JK flip-flops. It accepts one command at a time over a valid/ready handshake and translates it into per-bit J/K drive. Commands cover masked set, clear, toggle and load, plus multi-cycle up/down counting built from synchronous JK counter equations. It is the sequencing layer between software-visible commands and the JK storage cells.

## Interface
- WIDTH, 8, number of JK cells in the bank
- LEN_W, 8, width of the count-length field
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command (IDLE only)
- cmd_op  in  3  opcode (see Operation)
- cmd_mask  in  WIDTH  per-bit enable for SET/CLR/TGL/LOAD
- cmd_data  in  WIDTH  load value for LOAD
- cmd_len  in  LEN_W  count steps for CNTUP/CNTDN
- q  out  WIDTH  JK bank state
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on command completion

## Operation
- Opcodes and drive for each bit i:
  - 0 NOP: J=K=0.
  - 1 SET: J=mask, K=0.
  - 2 CLR: J=0, K=mask.
  - 3 TGL: J=K=mask.
  - 4 LOAD: J=mask&data, K=mask&~data.
  - 5 CNTUP: J=K=1 for bit 0; bit i>0 has J=K=&q[i-1:0].
  - 6 CNTDN: J=K=1 for bit 0; bit i>0 has J=K=&~q[i-1:0].
  - 7 reserved: executes as NOP and still produces done.
- Counting ignores cmd_mask, operates on the full bank, and wraps modulo 2^WIDTH (0xFF+1 → 0x00; 0x00−1 → 0xFF).
- Handshake: a command is accepted on a clk edge where cmd_valid && cmd_ready. op/mask/data/len are registered at acceptance; input changes afterwards are ignored.
- FSM states:
  - IDLE: ready=1. On accept, go to EXEC.
  - EXEC: J/K applied. A step counter is loaded at acceptance with 1 for single-cycle ops and with cmd_len for counts. Go to DONE when the counter reaches its last step.
  - DONE: done=1 for exactly one cycle. Go to IDLE.
- cmd_len=0 on a count: EXEC lasts 1 cycle with J=K=0, so q is unchanged and done still pulses.
- Reset (reset==0 at an edge) forces q=0, state IDLE, done=0, busy=0 from any state. An aborted command never produces done. cmd_ready is 0 while reset is low and 1 in the first cycle after release.
- cmd_valid held high in DONE is not accepted until the following IDLE cycle.

## Timing
- Command accepted at the edge ending cycle T.
- EXEC occupies cycles T+1..T+L, with L=1 for single-cycle ops and L=max(cmd_len,1) for counts.
- q updates at each EXEC edge. The final value is visible in cycle T+L+1.
- done is high in cycle T+L+1. cmd_ready is high again in T+L+2.
- Back-to-back single-cycle commands: 3-cycle issue interval.
- busy is high T+1..T+L+1.
- No combinational path from cmd_* to any output.

## Structure
- Shared package jk_ctrl_pkg holds:
  - op_e enum (NOP, SET, CLR, TGL, LOAD, CNTUP, CNTDN, RSVD), 3 bits.
  - state_e enum (IDLE, EXEC, DONE).
- Sub-module jk_cell: a single JK flip-flop (clk, reset synchronous active-low, j, k → q). Behaviour: hold / reset-to-0 / set-to-1 / toggle. Instantiated WIDTH times via generate.
- jk_bank_ctrl contains the FSM, command registers, step counter and the J/K vector decode.

## Test plan
- Reset held low for 2 cycles with cmd_valid=1, then released → q=0x00, done never pulses; cmd_ready=1 in the first cycle after release.
- SET mask=0x0F from q=0x00, then TGL mask=0xFF → q=0x0F after the first command and q=0xF0 after the second; each done pulses exactly once, 2 cycles after its accept.
- LOAD mask=0xF0 data=0xA5 from q=0x0F → q=0xAF; issue interval between accepts is exactly 3 cycles.
- CNTUP len=3 from q=0xFE → q sequence 0xFF, 0x00, 0x01; done in cycle T+4; busy high T+1..T+4.
- CNTDN len=0 and opcode 7 from q=0x33 → q stays 0x33; done pulses for each command.
- CNTUP len=10, with reset asserted in the 4th EXEC cycle → q=0x00 next cycle, no done, FSM back in IDLE.
